// File: rtl/rgb2ycbcr_stream.sv
`default_nettype none
// rgb2ycbcr_stream: LANES-wide RGB to YCbCr (BT.601 full or studio range) converter,
// 3-stage pipeline (products, sums, shift/offset/clip) under one global stall enable.
module rgb2ycbcr_stream #(
  parameter int LANES = 8,
  parameter int PIX_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [LANES*3*PIX_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_mode,
  input  logic                     i_last,
  output logic [LANES*PIX_W-1:0]   o_y,
  output logic [LANES*PIX_W-1:0]   o_cb,
  output logic [LANES*PIX_W-1:0]   o_cr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);

  localparam int W = PIX_W + 11;
  localparam logic signed [W-1:0] ZERO = '0;
  localparam logic signed [W-1:0] RND  = W'(128);
  localparam logic signed [W-1:0] HALF = W'(2 ** (PIX_W - 1));
  localparam logic signed [W-1:0] LOW  = W'(16 * 2 ** (PIX_W - 8));
  localparam logic signed [W-1:0] MAXV = W'(2 ** PIX_W - 1);

  // Index = 3*output + input, outputs ordered Y, Cb, Cr and inputs R, G, B.
  function automatic logic signed [W-1:0] coef(input logic mode, input int idx);
    int c;
    case (idx)
      0:       c = mode ? 66   : 77;
      1:       c = mode ? 129  : 150;
      2:       c = mode ? 25   : 29;
      3:       c = mode ? -38  : -43;
      4:       c = mode ? -74  : -85;
      5:       c = mode ? 112  : 128;
      6:       c = mode ? 112  : 128;
      7:       c = mode ? -94  : -107;
      default: c = mode ? -18  : -21;
    endcase
    return W'(c);
  endfunction

  function automatic logic [PIX_W-1:0] clip(input logic signed [W-1:0] v);
    if (v < ZERO) return '0;
    if (v > MAXV) return '1;
    return v[PIX_W-1:0];
  endfunction

  logic en;
  logic v1, v2, m1, m2, l1, l2;

  assign en      = !o_valid | i_ready;
  assign o_ready = en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m1      <= 1'b0;
      m2      <= 1'b0;
      l1      <= 1'b0;
      l2      <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (en) begin
      v1      <= i_valid;
      m1      <= i_mode;
      l1      <= i_valid & i_last;
      v2      <= v1;
      m2      <= m1;
      l2      <= l1;
      o_valid <= v2;
      o_last  <= l2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [W-1:0] x    [3];
    logic signed [W-1:0] prod [9];
    logic signed [W-1:0] sum  [3];
    logic signed [W-1:0] res  [3];
    logic [PIX_W-1:0]    q    [3];

    for (genvar c = 0; c < 3; c++) begin : g_comp
      assign x[c]   = W'(i_data[k*3*PIX_W + (2-c)*PIX_W +: PIX_W]);
      // Mode for the S3 offset comes from the beat currently sitting in S2.
      assign res[c] = (sum[c] >>> 8) + ((c == 0) ? (m2 ? LOW : ZERO) : HALF);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int j = 0; j < 9; j++) prod[j] <= '0;
        for (int i = 0; i < 3; i++) begin
          sum[i] <= '0;
          q[i]   <= '0;
        end
      end else if (en) begin
        for (int j = 0; j < 9; j++) prod[j] <= x[j % 3] * coef(i_mode, j);
        for (int i = 0; i < 3; i++) begin
          sum[i] <= prod[3*i] + prod[3*i+1] + prod[3*i+2] + RND;
          q[i]   <= clip(res[i]);
        end
      end
    end

    assign o_y[k*PIX_W +: PIX_W]  = q[0];
    assign o_cb[k*PIX_W +: PIX_W] = q[1];
    assign o_cr[k*PIX_W +: PIX_W] = q[2];
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_stream.sv
`default_nettype none
// Bench for rgb2ycbcr_stream: directed colour beats, backpressure, mode alternation
// and mid-stream reset, checked against a behavioural conversion model.
module tb_rgb2ycbcr_stream;
  localparam int LANES = 8;
  localparam int PIX_W = 8;
  localparam int DW = LANES * 3 * PIX_W;
  localparam int OW = LANES * PIX_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready_o;
  logic          mode = 1'b0;
  logic          in_last = 1'b0;
  logic [OW-1:0] y, cb, cr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  always #5 clk = ~clk;

  rgb2ycbcr_stream #(.LANES(LANES), .PIX_W(PIX_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(in_valid), .o_ready(in_ready_o),
    .i_mode(mode), .i_last(in_last), .o_y(y), .o_cb(cb), .o_cr(cr),
    .o_valid(out_valid), .i_ready(out_ready), .o_last(out_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;

  logic       lit_en = 1'b0;
  logic [7:0] lit_y = '0, lit_cb = '0, lit_cr = '0;

  typedef struct {
    logic [OW-1:0] y, cb, cr;
    logic          lst;
    int            acc;
    int            st;
    logic          lit;
    logic [7:0]    ly, lcb, lcr;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] clamp8(int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [23:0] conv(int r, int g, int b, logic m);
    int yy, cbv, crv;
    if (!m) begin
      yy  = (77*r + 150*g + 29*b + 128) >>> 8;
      cbv = ((-43*r - 85*g + 128*b + 128) >>> 8) + 128;
      crv = ((128*r - 107*g - 21*b + 128) >>> 8) + 128;
    end else begin
      yy  = ((66*r + 129*g + 25*b + 128) >>> 8) + 16;
      cbv = ((-38*r - 74*g + 112*b + 128) >>> 8) + 128;
      crv = ((112*r - 94*g - 18*b + 128) >>> 8) + 128;
    end
    return {clamp8(yy), clamp8(cbv), clamp8(crv)};
  endfunction

  function automatic exp_t model(logic [DW-1:0] d, logic m, logic l);
    exp_t e;
    logic [23:0] o;
    for (int k = 0; k < LANES; k++) begin
      o = conv(int'(d[k*24+16 +: 8]), int'(d[k*24+8 +: 8]), int'(d[k*24 +: 8]), m);
      e.y[k*8 +: 8]  = o[23:16];
      e.cb[k*8 +: 8] = o[15:8];
      e.cr[k*8 +: 8] = o[7:0];
    end
    e.lst = l;
    e.acc = 0;
    e.st  = 0;
    e.lit = 1'b0;
    e.ly  = '0;
    e.lcb = '0;
    e.lcr = '0;
    return e;
  endfunction

  function automatic logic [DW-1:0] solid(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {LANES{r, g, b}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*24 +: 24] = 24'($urandom());
    return d;
  endfunction

  // Compare process: one sample per cycle on the falling edge.
  initial begin
    logic          prev_ov, prev_xfer, prev_last;
    logic [OW-1:0] prev_y, prev_cb, prev_cr;
    exp_t          e;
    prev_ov = 1'b0; prev_xfer = 1'b0; prev_last = 1'b0;
    prev_y = '0; prev_cb = '0; prev_cr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_ov = 1'b0;
        prev_xfer = 1'b0;
      end else begin
        chk("ready_rule", 64'(in_ready_o), 64'(!out_valid || out_ready));
        if (out_valid && (!prev_ov || prev_xfer)) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_beat: o_valid 1 with no beat outstanding, required 0 (cycle %0d)", cyc);
          end else begin
            chk("latency", 64'(cyc - q[0].acc), 64'(3 + stalls - q[0].st));
          end
        end
        if (out_valid && prev_ov && !prev_xfer)
          chk("stable_hold", {y ^ prev_y, 7'd0, out_last ^ prev_last} | 64'(cb ^ prev_cb) | 64'(cr ^ prev_cr), 64'd0);
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("y_data", 64'(y), 64'(e.y));
          chk("cb_data", 64'(cb), 64'(e.cb));
          chk("cr_data", 64'(cr), 64'(e.cr));
          chk("o_last", 64'(out_last), 64'(e.lst));
          if (e.lit)
            chk("literal_ycbcr", {y, cb[7:0], cr[7:0]} , {{LANES{e.ly}}, e.lcb, e.lcr});
        end
        if (out_valid && !out_ready) stalls++;
        if (in_valid && in_ready_o) begin
          e = model(data, mode, in_last);
          e.acc = cyc; e.st = stalls;
          e.lit = lit_en; e.ly = lit_y; e.lcb = lit_cb; e.lcr = lit_cr;
          q.push_back(e);
        end
        prev_ov = out_valid;
        prev_xfer = out_valid && out_ready;
        prev_y = y; prev_cb = cb; prev_cr = cr; prev_last = out_last;
      end
      cyc++;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic m, input logic l,
                      input logic le, input logic [7:0] ly, input logic [7:0] lcb, input logic [7:0] lcr);
    int n;
    n = 0;
    data = d; mode = m; in_last = l;
    lit_en = le; lit_y = ly; lit_cb = lcb; lit_cr = lcr;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready_o) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: o_ready stayed %0b, required 1", in_ready_o);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0; in_last = 1'b0; lit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_o_valid", 64'(out_valid), 64'd0);
    chk("reset_o_last", 64'(out_last), 64'd0);
    chk("reset_o_y", 64'(y), 64'd0);
    chk("reset_o_cbcr", 64'(cb | cr), 64'd0);
    chk("reset_o_ready", 64'(in_ready_o), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Directed colours with hand-computed results
    send(solid(8'd255, 8'd255, 8'd255), 1'b0, 1'b0, 1'b1, 8'd255, 8'd128, 8'd128);
    send(solid(8'd0,   8'd0,   8'd0),   1'b0, 1'b0, 1'b1, 8'd0,   8'd128, 8'd128);
    send(solid(8'd255, 8'd0,   8'd0),   1'b0, 1'b0, 1'b1, 8'd77,  8'd85,  8'd255);
    send(solid(8'd0,   8'd0,   8'd255), 1'b0, 1'b1, 1'b1, 8'd29,  8'd255, 8'd107);
    send(solid(8'd255, 8'd255, 8'd255), 1'b1, 1'b0, 1'b1, 8'd235, 8'd128, 8'd128);
    send(solid(8'd0,   8'd0,   8'd0),   1'b1, 1'b1, 1'b1, 8'd16,  8'd128, 8'd128);
    idle(6);

    // Per-lane random pixels with bubbles between beats
    for (int i = 0; i < 6; i++) begin
      send(rand_data(), 1'((i / 2) % 2), 1'(i == 5), 1'b0, '0, '0, '0);
      idle(i % 3);
    end
    idle(6);

    // Ten-beat stream with downstream stalled for four cycles mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(rand_data(), 1'(i % 2), 1'(i == 4 || i == 9), 1'b0, '0, '0, '0);
      end
      begin
        repeat (4) @(posedge clk);
        #2; out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2; out_ready = 1'b1;
      end
    join
    idle(6);

    // Mode alternating on white
    for (int i = 0; i < 6; i++)
      send(solid(8'd255, 8'd255, 8'd255), 1'(i % 2), 1'b0, 1'b1,
           (i % 2 == 1) ? 8'd235 : 8'd255, 8'd128, 8'd128);
    idle(6);

    // Reset with three beats in flight
    send(solid(8'd10, 8'd20, 8'd30), 1'b0, 1'b0, 1'b0, '0, '0, '0);
    send(solid(8'd40, 8'd50, 8'd60), 1'b1, 1'b0, 1'b0, '0, '0, '0);
    send(solid(8'd70, 8'd80, 8'd90), 1'b0, 1'b1, 1'b0, '0, '0, '0);
    #1;
    chk("pre_reset_o_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_o_valid", 64'(out_valid), 64'd0);
    chk("async_rst_o_y", 64'(y), 64'd0);
    chk("async_rst_o_last", 64'(out_last), 64'd0);
    chk("async_rst_o_ready", 64'(in_ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);
    send(solid(8'd255, 8'd255, 8'd255), 1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128);

    begin
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_o_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
